// File: rtl/varredura_display_if.sv
// Display-scanner bus: four segment words with blink/enable controls in,
// and the multiplexed segment bus with digit enables out.
interface varredura_display_if;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] seg3;
    logic [3:0] pisca;
    logic       habilita;
    logic [6:0] segmentos;
    logic [3:0] digito;
    logic       fase_pisca;

    modport master (
        output seg0, seg1, seg2, seg3, pisca, habilita,
        input  segmentos, digito, fase_pisca
    );

    modport slave (
        input  seg0, seg1, seg2, seg3, pisca, habilita,
        output segmentos, digito, fase_pisca
    );
endinterface

// File: rtl/varredura_display.sv
// Four-digit multiplexed 7-segment scanner: one shared segment bus, one-hot
// active-low digit enables, a blank guard cycle between slots and blink gating.
module varredura_display #(
    parameter int DIV             = 50000,
    parameter int BLINK_DIV       = 250,
    parameter bit SEG_ATIVO_BAIXO = 1'b1
) (
    input logic              clock,
    input logic              reset,
    varredura_display_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] BLANK = SEG_ATIVO_BAIXO ? 7'h7F : 7'h00;

    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic [BW-1:0] bcnt, bcnt_next;
    logic          phase, phase_next;
    logic          guard, guard_next;
    logic          tick;
    logic [6:0]    seg_sel, seg_next, seg_q;
    logic [3:0]    dig_next, dig_q;

    assign tick = (cnt == CW'(DIV - 1));

    // Scan timing: prescaler, slot index and blink phase all advance on tick.
    always_comb begin
        cnt_next   = tick ? '0 : cnt + CW'(1);
        idx_next   = idx;
        bcnt_next  = bcnt;
        phase_next = phase;
        guard_next = tick;
        if (tick) begin
            idx_next = idx + 2'd1;
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt_next  = '0;
                phase_next = ~phase;
            end else begin
                bcnt_next = bcnt + BW'(1);
            end
        end
    end

    always_comb begin
        seg_sel = bus.seg0;
        case (idx_next)
            2'd0: seg_sel = bus.seg0;
            2'd1: seg_sel = bus.seg1;
            2'd2: seg_sel = bus.seg2;
            2'd3: seg_sel = bus.seg3;
            default: seg_sel = bus.seg0;
        endcase
    end

    // Output words are built from next-state values so they line up with the
    // registered slot; the guard cycle hides segment ghosting between digits.
    always_comb begin
        dig_next = 4'b1111;
        seg_next = BLANK;
        if (bus.habilita && !guard_next) begin
            dig_next = ~(4'b0001 << idx_next);
            if (bus.pisca[idx_next] && phase_next) begin
                seg_next = BLANK;
            end else begin
                seg_next = seg_sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= 2'd0;
            bcnt  <= '0;
            phase <= 1'b0;
            guard <= 1'b0;
            seg_q <= BLANK;
            dig_q <= 4'b1111;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            bcnt  <= bcnt_next;
            phase <= phase_next;
            guard <= guard_next;
            seg_q <= seg_next;
            dig_q <= dig_next;
        end
    end

    assign bus.segmentos  = seg_q;
    assign bus.digito     = dig_q;
    assign bus.fase_pisca = phase;
endmodule

// File: tb/tb_varredura_display.sv
// Randomised self-checking bench for varredura_display against a closed-form
// model derived from the cycle count since reset.
module tb_varredura_display;
    localparam int DIV       = 4;
    localparam int BLINK_DIV = 2;
    localparam logic [6:0] BLANK = 7'h7F;

    logic clock = 1'b0;
    logic reset;

    varredura_display_if bus();

    varredura_display #(
        .DIV(DIV),
        .BLINK_DIV(BLINK_DIV),
        .SEG_ATIVO_BAIXO(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         passed = 0;
    int         n = 0;
    logic [6:0] segv [4];
    logic [3:0] piscav;
    logic       habv;
    int         last_toggle = 0;
    logic       prev_fase = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d after reset)",
                      tag, observed, expected, n);
    endtask

    task automatic applyStimulus(input logic [6:0] s0, input logic [6:0] s1,
                                 input logic [6:0] s2, input logic [6:0] s3,
                                 input logic [3:0] p, input logic h);
        segv[0] = s0; segv[1] = s1; segv[2] = s2; segv[3] = s3;
        piscav = p;
        habv   = h;
        bus.seg0 = s0; bus.seg1 = s1; bus.seg2 = s2; bus.seg3 = s3;
        bus.pisca    = p;
        bus.habilita = h;
    endtask

    // Slot k covers cycles [k*DIV, (k+1)*DIV); the phase flips every BLINK_DIV slots.
    function automatic int m_idx();
        return (n / DIV) % 4;
    endfunction

    function automatic logic m_phase();
        return ((n / DIV) / BLINK_DIV) % 2 == 1;
    endfunction

    function automatic logic m_guard();
        return (n > 0) && (n % DIV == 0);
    endfunction

    task automatic step();
        logic [3:0] ed;
        logic [6:0] es;
        logic       ep;
        int         k;
        @(posedge clock);
        if (reset) n = 0;
        else n++;
        #1;
        k  = m_idx();
        ep = (n == 0) ? 1'b0 : m_phase();
        if (n == 0 || !habv || m_guard()) begin
            ed = 4'hF;
            es = BLANK;
        end else begin
            ed = ~(4'b0001 << k);
            es = (piscav[k] && m_phase()) ? BLANK : segv[k];
        end
        checkOutput("digito", 32'(bus.digito), 32'(ed));
        checkOutput("segmentos", 32'(bus.segmentos), 32'(es));
        checkOutput("fase_pisca", 32'(bus.fase_pisca), 32'(ep));
        checkOutput("one_active", 32'($countones(~bus.digito) <= 1), 32'd1);
        if (n == 0) begin
            last_toggle = 0;
            prev_fase   = 1'b0;
        end else if (bus.fase_pisca !== prev_fase) begin
            checkOutput("blink_half_period", 32'(n - last_toggle), 32'(BLINK_DIV * DIV));
            last_toggle = n;
            prev_fase   = bus.fase_pisca;
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    // Advance until the second cycle of the requested slot (ph < 0: any phase).
    task automatic waitSlot(input int di, input int ph, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n % DIV == 1 && m_idx() == di && (ph < 0 || int'(m_phase()) == ph)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checkOutput({tag, "_reached"}, 32'(found), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(7'h01, 7'h02, 7'h04, 7'h08, 4'b0000, 1'b1);
        step();
        checkOutput("reset_digito", 32'(bus.digito), 32'hF);
        checkOutput("reset_segmentos", 32'(bus.segmentos), 32'(BLANK));
        reset = 1'b0;
        run(20);

        applyStimulus(7'h01, 7'h02, 7'h04, 7'h08, 4'b0010, 1'b1);
        run(48);

        waitSlot(2, -1, "slot2_short");
        applyStimulus(7'h01, 7'h02, 7'h04, 7'h08, 4'b0010, 1'b0);
        step();
        checkOutput("hab_drop_digito", 32'(bus.digito), 32'hF);
        applyStimulus(7'h01, 7'h02, 7'h04, 7'h08, 4'b0010, 1'b1);
        step();
        checkOutput("hab_rise_digito", 32'(bus.digito), 32'hB);
        run(8);

        waitSlot(2, -1, "slot2_long");
        applyStimulus(7'h01, 7'h02, 7'h04, 7'h08, 4'b0010, 1'b0);
        run(3);
        applyStimulus(7'h01, 7'h02, 7'h04, 7'h08, 4'b0010, 1'b1);
        run(10);

        waitSlot(3, -1, "slot3_seg");
        applyStimulus(7'h01, 7'h02, 7'h04, 7'h3F, 4'b0010, 1'b1);
        step();
        checkOutput("seg3_update", 32'(bus.segmentos), 32'h3F);
        checkOutput("seg3_digito", 32'(bus.digito), 32'h7);
        run(6);

        waitSlot(3, 1, "slot3_phase1");
        reset = 1'b1;
        step();
        checkOutput("midreset_digito", 32'(bus.digito), 32'hF);
        checkOutput("midreset_fase", 32'(bus.fase_pisca), 32'd0);
        reset = 1'b0;
        step();
        checkOutput("midreset_first", 32'(bus.digito), 32'hE);
        run(12);

        for (int i = 0; i < 10000; i++) begin
            applyStimulus(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
                          4'($urandom), $urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset = 1'b0;
        run(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
